muldiv_unit: RTL

Multicycle signed multiply/divide engine that owns the HI and LO registers of the multicycle CPU. The control unit pulses `start` when it decodes mult or div, then waits while `busy` is high. The `hi`/`lo` outputs feed the HI/LO inputs of the register-write-data mux used by mfhi/mflo. Operands come directly from the A and B register outputs: `a` = rs, `b` = rt.

---
 rtl/muldiv_pkg.sv | 16 +
 rtl/muldiv_div_step.sv | 28 ++
 rtl/muldiv_unit.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the multicycle multiply/divide engine.
package muldiv_pkg;

    localparam int ITER = 32;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MULT = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring-division iteration on unsigned magnitudes.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH:0]   divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] rem_sh;
    logic           fits;

    // The remainder stays below the divisor (at most 2^(WIDTH-1)), so WIDTH bits suffice between steps.
    always_comb begin
        rem_sh = {rem_i, quo_i[WIDTH-1]};
        fits   = (rem_sh >= divisor_i);
        if (fits) begin
            rem_o = WIDTH'(rem_sh - divisor_i);
            quo_o = {quo_i[WIDTH-2:0], 1'b1};
        end else begin
            rem_o = rem_sh[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Multicycle signed mult/div engine owning the CPU's HI/LO registers.
//   state   | meaning
//   IDLE    | waiting for start, busy low
//   MULT    | radix-2 Booth iterations
//   DIV     | restoring division iterations on magnitudes
//   DONE    | one-cycle done pulse, results valid
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = ITER
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0] mplr_q, mplr_d;
    logic             qm1_q, qm1_d;
    logic [WIDTH:0]   mcand_q, mcand_d;
    logic             quo_neg_q, quo_neg_d;
    logic             rem_neg_q, rem_neg_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic [WIDTH:0]   booth_sum;
    logic [WIDTH:0]   booth_acc;
    logic [WIDTH-1:0] booth_mplr;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quo;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    // Booth add/subtract followed by arithmetic shift of {acc, mplr, q-1}.
    always_comb begin
        unique case ({mplr_q[0], qm1_q})
            2'b01:   booth_sum = acc_q + mcand_q;
            2'b10:   booth_sum = acc_q - mcand_q;
            default: booth_sum = acc_q;
        endcase
        booth_acc  = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
        booth_mplr = {booth_sum[0], mplr_q[WIDTH-1:1]};
    end

    div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_i     (acc_q[WIDTH-1:0]),
        .quo_i     (mplr_q),
        .divisor_i (mcand_q),
        .rem_o     (step_rem),
        .quo_o     (step_quo)
    );

    // Truncating-division sign fixup; -2^(W-1)/-1 wraps back to 0x80..0 naturally.
    always_comb begin
        a_mag = a[WIDTH-1] ? ({WIDTH{1'b0}} - a) : a;
        b_mag = b[WIDTH-1] ? ({WIDTH{1'b0}} - b) : b;
        q_fix = quo_neg_q ? ({WIDTH{1'b0}} - step_quo) : step_quo;
        r_fix = rem_neg_q ? ({WIDTH{1'b0}} - step_rem) : step_rem;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mplr_d    = mplr_q;
        qm1_d     = qm1_q;
        mcand_d   = mcand_q;
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;
        dz_d      = dz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cnt_d = '0;
                    dz_d  = 1'b0;
                    acc_d = '0;
                    qm1_d = 1'b0;
                    if (op == OP_MULT) begin
                        mplr_d  = b;
                        mcand_d = {a[WIDTH-1], a};
                        state_d = ST_MULT;
                    end else begin
                        mplr_d    = a_mag;
                        mcand_d   = {1'b0, b_mag};
                        quo_neg_d = a[WIDTH-1] ^ b[WIDTH-1];
                        rem_neg_d = a[WIDTH-1];
                        if (b == '0) begin
                            dz_d    = 1'b1;
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_DIV;
                        end
                    end
                end
            end
            ST_MULT: begin
                acc_d  = booth_acc;
                mplr_d = booth_mplr;
                qm1_d  = mplr_q[0];
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    hi_d    = booth_acc[WIDTH-1:0];
                    lo_d    = booth_mplr;
                    state_d = ST_DONE;
                end
            end
            ST_DIV: begin
                acc_d  = {1'b0, step_rem};
                mplr_d = step_quo;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    hi_d    = r_fix;
                    lo_d    = q_fix;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            mplr_q    <= '0;
            qm1_q     <= 1'b0;
            mcand_q   <= '0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mplr_q    <= mplr_d;
            qm1_q     <= qm1_d;
            mcand_q   <= mcand_d;
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
            dz_q      <= dz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign div_zero = dz_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule
